// File: rtl/clock_time_ctrl_pkg.sv
// Shared definitions for the clock timekeeping block: mode codes, BCD limits, BCD increment.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package clock_time_ctrl_pkg;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;
    localparam logic [1:0] MODE_SET_SEC  = 2'd3;

    localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
    localparam logic [7:0] BCD_MS_MAX   = 8'h59;

    // Time of day, one BCD byte per field ([7:4] tens, [3:0] ones).
    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] minute;
        logic [7:0] second;
    } time_t;

    // Next BCD value with wrap to 00 once the full byte equals max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        if (val == max) begin
            return 8'h00;
        end else if (val[3:0] == 4'd9) begin
            return {val[7:4] + 4'd1, 4'd0};
        end else begin
            return {val[7:4], val[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/clock_time_ctrl_key_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, one-cycle pulse on accepted press.
// Latency: press_vld rises DEBOUNCE_CYC+2..+3 cycles after a clean raw rising edge.
// Backpressure: none; press_vld is a single-cycle strobe, release produces nothing.
//
// Ports: core_clk/arst_n clock and async active-low reset; key_raw asynchronous active-high
// button; press_vld registered one-cycle pulse on the debounced 0->1 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 20_000
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic key_raw,
    output logic press_vld
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] stab_cnt_q;

    // The counter measures how long the synchronised key has disagreed with the accepted
    // level; any return to agreement restarts the measurement.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q     <= 2'b00;
            level_q    <= 1'b0;
            stab_cnt_q <= '0;
            press_vld  <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_raw};
            press_vld <= 1'b0;
            if (sync_q[1] != level_q) begin
                if (stab_cnt_q == CNT_LAST) begin
                    level_q    <= sync_q[1];
                    stab_cnt_q <= '0;
                    press_vld  <= sync_q[1];
                end else begin
                    stab_cnt_q <= stab_cnt_q + CW'(1);
                end
            end else begin
                stab_cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Digital clock core: BCD h/m/s counting from a 1 Hz prescaler plus a two-button set-mode FSM.
// Latency: all outputs update one cycle after the causing tick or debounced press pulse.
// Backpressure: none; buttons are sampled freely, a mode press on the same cycle drops an up press.
//
// Ports: CP_1Mhz system clock; nCR async active-low reset; key_mode/key_up raw buttons;
// hour/minute/second BCD time; mode 0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC;
// blank per-digit blank mask {hour[1:0], minute[1:0], second[1:0]}.
module clock_time_ctrl
    import clock_time_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 1_000_000,
    parameter int DEBOUNCE_CYC = 20_000,
    parameter int BLINK_DIV    = 250_000
) (
    input  logic       CP_1Mhz,
    input  logic       nCR,
    input  logic       key_mode,
    input  logic       key_up,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [1:0] mode,
    output logic [5:0] blank
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic          mode_press_vld;
    logic          up_press_vld;
    logic          up_ok;
    logic          tick_vld;
    logic          blink_clr;
    logic [1:0]    mode_q;
    logic [1:0]    mode_nxt;
    logic [TW-1:0] tick_cnt_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;
    time_t         time_q;
    time_t         time_nxt;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_mode (
        .core_clk  (CP_1Mhz),
        .arst_n    (nCR),
        .key_raw   (key_mode),
        .press_vld (mode_press_vld)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up (
        .core_clk  (CP_1Mhz),
        .arst_n    (nCR),
        .key_raw   (key_up),
        .press_vld (up_press_vld)
    );

    // ---------------- mode FSM: state register ----------------
    always_ff @(posedge CP_1Mhz or negedge nCR) begin
        if (!nCR) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= mode_nxt;
        end
    end

    // ---------------- mode FSM: next state ----------------
    always_comb begin
        mode_nxt = mode_q;
        if (mode_press_vld) begin
            case (mode_q)
                MODE_RUN:      mode_nxt = MODE_SET_HOUR;
                MODE_SET_HOUR: mode_nxt = MODE_SET_MIN;
                MODE_SET_MIN:  mode_nxt = MODE_SET_SEC;
                default:       mode_nxt = MODE_RUN;
            endcase
        end
    end

    // ---------------- mode FSM: outputs ----------------
    // Only the field being set blinks; phase 0 is the visible half-period.
    always_comb begin
        blank = 6'b000000;
        case (mode_q)
            MODE_SET_HOUR: blank[5:4] = {2{blink_phase_q}};
            MODE_SET_MIN:  blank[3:2] = {2{blink_phase_q}};
            MODE_SET_SEC:  blank[1:0] = {2{blink_phase_q}};
            default:       blank      = 6'b000000;
        endcase
    end

    // ---------------- 1 Hz prescaler ----------------
    // Held at zero outside RUN and cleared on every mode change, so a return to RUN
    // always waits a full TICK_DIV period before the first tick.
    assign tick_vld = (mode_q == MODE_RUN) && (tick_cnt_q == TICK_LAST);

    always_ff @(posedge CP_1Mhz or negedge nCR) begin
        if (!nCR) begin
            tick_cnt_q <= '0;
        end else if (mode_press_vld || (mode_q != MODE_RUN) || tick_vld) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
        end
    end

    // ---------------- time registers ----------------
    // A mode press on the same cycle as an up press takes priority.
    assign up_ok = up_press_vld && !mode_press_vld;

    always_comb begin
        time_nxt = time_q;
        case (mode_q)
            MODE_RUN: begin
                if (tick_vld) begin
                    time_nxt.second = bcd_inc(time_q.second, BCD_MS_MAX);
                    if (time_q.second == BCD_MS_MAX) begin
                        time_nxt.minute = bcd_inc(time_q.minute, BCD_MS_MAX);
                        if (time_q.minute == BCD_MS_MAX) begin
                            time_nxt.hour = bcd_inc(time_q.hour, BCD_HOUR_MAX);
                        end
                    end
                end
            end
            MODE_SET_HOUR: begin
                if (up_ok) time_nxt.hour = bcd_inc(time_q.hour, BCD_HOUR_MAX);
            end
            MODE_SET_MIN: begin
                if (up_ok) time_nxt.minute = bcd_inc(time_q.minute, BCD_MS_MAX);
            end
            default: begin
                if (up_ok) time_nxt.second = bcd_inc(time_q.second, BCD_MS_MAX);
            end
        endcase
    end

    always_ff @(posedge CP_1Mhz or negedge nCR) begin
        if (!nCR) begin
            time_q <= '0;
        end else begin
            time_q <= time_nxt;
        end
    end

    // ---------------- blink generator ----------------
    // Free-running, but restarted on entry to any set state so each field starts visible.
    assign blink_clr = mode_press_vld && (mode_nxt != MODE_RUN);

    always_ff @(posedge CP_1Mhz or negedge nCR) begin
        if (!nCR) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_clr) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BW'(1);
        end
    end

    assign hour   = time_q.hour;
    assign minute = time_q.minute;
    assign second = time_q.second;
    assign mode   = mode_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl with small prescaler/debounce/blink periods.
// Reference keeps time as seconds-of-day and derives ticks and blink phase from elapsed cycles.
// Stimulus: directed scenario sequence with randomized press counts, hold lengths and run times.
module tb_clock_time_ctrl;

    localparam int TICK  = 10;
    localparam int DEB   = 4;
    localparam int BLINK = 6;

    logic       clk      = 1'b0;
    logic       nCR      = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_up   = 1'b0;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic [1:0] mode;
    logic [5:0] blank;

    clock_time_ctrl #(
        .TICK_DIV     (TICK),
        .DEBOUNCE_CYC (DEB),
        .BLINK_DIV    (BLINK)
    ) dut (
        .CP_1Mhz  (clk),
        .nCR      (nCR),
        .key_mode (key_mode),
        .key_up   (key_up),
        .hour     (hour),
        .minute   (minute),
        .second   (second),
        .mode     (mode),
        .blank    (blank)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; at a falling edge this names the edge just passed.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference state
    int m_mode = 0;     // 0 run, 1 hour, 2 minute, 3 second
    int tod    = 0;     // seconds of day, as of the last entry into RUN (or frozen value when setting)
    int run_e  = 0;     // edge at which RUN was (re)entered
    int set_e  = 0;     // edge at which the current set state was entered
    bit mode_chg;
    int chg_cyc;

    function automatic logic [7:0] bcd8(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int cur_tod();
        if (m_mode == 0) return (tod + (cyc - run_e) / TICK) % 86400;
        return tod;
    endfunction

    function automatic logic [23:0] tod_bcd(input int t);
        return {bcd8(t / 3600), bcd8((t / 60) % 60), bcd8(t % 60)};
    endfunction

    function automatic logic [5:0] exp_blank();
        logic [1:0] b;
        b = ((((cyc - set_e) / BLINK) % 2) == 1) ? 2'b11 : 2'b00;
        case (m_mode)
            1:       return {b, 4'b0000};
            2:       return {2'b00, b, 2'b00};
            3:       return {4'b0000, b};
            default: return 6'b000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_time"},  32'({hour, minute, second}), 32'(tod_bcd(cur_tod())));
        check({tag, "_mode"},  32'(mode), 32'(m_mode));
        check({tag, "_blank"}, 32'(blank), 32'(exp_blank()));
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
        check("schedule", 32'(cyc), 32'(target));
    endtask

    // Apply the reference effect of an accepted mode press that landed on edge c.
    task automatic model_mode(input int c);
        if (m_mode == 0) tod = (tod + (c - run_e) / TICK) % 86400;
        m_mode = (m_mode + 1) % 4;
        if (m_mode == 0) run_e = c;
        else             set_e = c;
    endtask

    task automatic model_up();
        int h, mi, s;
        h  = tod / 3600;
        mi = (tod / 60) % 60;
        s  = tod % 60;
        case (m_mode)
            1: h  = (h + 1) % 24;
            2: mi = (mi + 1) % 60;
            3: s  = (s + 1) % 60;
            default: ;
        endcase
        tod = h * 3600 + mi * 60 + s;
    endtask

    task automatic watch(input logic [1:0] m0, input bit pm, input bit accepted);
        if (mode_chg) begin
            check("blink_track", 32'(blank), 32'(exp_blank()));
        end else if (mode !== m0) begin
            mode_chg = 1'b1;
            chg_cyc  = cyc;
            if (pm && accepted) begin
                model_mode(cyc);
                check_all("mode_entry");
            end
        end
    endtask

    // Hold the chosen raw key(s) for 'hold' cycles, release, and let the release settle.
    task automatic press(input bit pm, input bit pu, input int hold);
        logic [1:0] m0;
        bit accepted;
        m0       = mode;
        mode_chg = 1'b0;
        accepted = (hold >= DEB);
        @(negedge clk);
        key_mode = pm;
        key_up   = pu;
        repeat (hold) begin
            @(negedge clk);
            watch(m0, pm, accepted);
        end
        key_mode = 1'b0;
        key_up   = 1'b0;
        repeat (DEB + 4) begin
            @(negedge clk);
            watch(m0, pm, accepted);
        end
        if (pm) check("mode_changed", 32'(mode_chg), 32'(accepted));
        else if (accepted && m_mode != 0) model_up();
    endtask

    task automatic ups(input int n);
        for (int i = 0; i < n; i++) press(1'b0, 1'b1, DEB + int'($urandom_range(0, 6)));
    endtask

    initial begin
        int k;
        int h, mi, s;

        // Reset state
        repeat (3) @(negedge clk);
        run_e = cyc;
        check_all("reset");
        nCR   = 1'b1;
        run_e = cyc;

        // Run 25 ticks, then asynchronous reset mid-cycle
        wait_to(run_e + 25 * TICK + 3);
        check_all("run25");
        @(posedge clk);
        #2 nCR = 1'b0;
        #1;
        m_mode = 0;
        tod    = 0;
        run_e  = cyc;
        check_all("async_rst");
        @(negedge clk);
        nCR   = 1'b1;
        run_e = cyc;

        // Hour setting with blink tracking, 25 presses wrap past 23
        press(1'b1, 1'b0, DEB + 2);
        ups(25);
        check_all("hour25");

        // Short glitch ignored, long hold counts once
        press(1'b0, 1'b1, int'($urandom_range(1, DEB - 1)));
        check_all("glitch");
        press(1'b0, 1'b1, 40);
        check_all("held40");
        ups(int'($urandom_range(0, 30)));
        check_all("hour_rand");

        // Minute setting across the 59 wrap, then simultaneous mode+up
        press(1'b1, 1'b0, DEB + 1);
        ups(int'($urandom_range(55, 70)));
        check_all("min_rand");
        press(1'b1, 1'b1, DEB + 2);
        check_all("simul");

        // Seconds frozen while setting, then first tick exactly one period after RUN entry
        ups(int'($urandom_range(0, 20)));
        repeat (5 * TICK) @(negedge clk);
        check_all("frozen");
        press(1'b1, 1'b0, DEB + 2);
        wait_to(run_e + TICK - 1);
        check_all("pre_tick");
        wait_to(run_e + TICK);
        check_all("first_tick");
        k = int'($urandom_range(20, 80));
        wait_to(run_e + k);
        check_all("run_rand");

        // Leave RUN at an arbitrary phase and load 23:59:58
        press(1'b1, 1'b0, DEB + int'($urandom_range(0, 3)));
        h  = tod / 3600;
        mi = (tod / 60) % 60;
        s  = tod % 60;
        ups((23 - h + 24) % 24);
        press(1'b1, 1'b0, DEB + 2);
        ups((59 - mi + 60) % 60);
        press(1'b1, 1'b0, DEB + 2);
        ups((58 - s + 60) % 60);
        check_all("loaded");
        press(1'b1, 1'b0, DEB + 2);
        wait_to(run_e + 2 * TICK - 1);
        check_all("t235959");
        check("midnight_pre", 32'({hour, minute, second}), 32'(24'h235959));
        wait_to(run_e + 2 * TICK);
        check("midnight", 32'({hour, minute, second}), 32'(24'h000000));
        wait_to(run_e + 3 * TICK);
        check_all("after_midnight");

        // Reset during a set with a press pending aborts both
        press(1'b1, 1'b0, DEB + 2);
        @(negedge clk);
        key_up = 1'b1;
        repeat (3) @(negedge clk);
        #2 nCR = 1'b0;
        #1;
        m_mode = 0;
        tod    = 0;
        run_e  = cyc;
        check_all("abort_rst");
        key_up = 1'b0;
        @(negedge clk);
        nCR   = 1'b1;
        run_e = cyc;
        wait_to(run_e + 3 * TICK + 4);
        check_all("abort_run");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
